// File: rtl/cp0_pkg.sv
// Purpose: shared CP0 register numbers, bit positions and FSM state type.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package cp0_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    localparam int IE_BIT  = 0;
    localparam int IM_LO   = 10;
    localparam int IM_HI   = 15;
    localparam int TMR_BIT = 15;

    typedef enum logic {
        RUN     = 1'b0,
        HANDLER = 1'b1
    } cp0_state_t;

endpackage

// File: rtl/irq_sync_edge.sv
// Purpose: multi-flop synchronizer followed by a registered rising-edge pulse.
// Latency: DEPTH+1 cycles from input rise to one-cycle o_rise pulse.
// Backpressure: none; a level change is reported once per rising edge.
//
// Ports: clk/rst (sync active-low), i_async level inputs, o_rise pulses.
module irq_sync_edge #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_sync [DEPTH];
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_rise;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
            r_rise <= '0;
        end else begin
            r_sync[0] <= i_async;
            for (int i = 1; i < DEPTH; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[DEPTH-1];
            r_rise <= r_sync[DEPTH-1] & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/cp0_intr_ctrl.sv
// Purpose: CP0 Status/Cause/EPC/Count/Compare plus interrupt take/eret FSM.
// Latency: irq pin to take >= SYNC_STAGES+2 cycles; Count match to take 2 cycles.
// Backpressure: take is held off while intr_ok is low or while in the handler.
//
// Ports: clk/rst (sync active-low); irq_ext async level lines; cp0_we/waddr/wdata
// mtc0 write; cp0_raddr/cp0_rdata mfc0 read (combinational); pc_x/intr_ok from
// X stage; eret return pulse; intr_take/intr_vector redirect; epc; in_handler.
module cp0_intr_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] ISR_VECTOR  = 32'h0000_0000,
    parameter int          N_EXT       = 5,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_EXT-1:0] irq_ext,
    input  logic             cp0_we,
    input  logic [4:0]       cp0_waddr,
    input  logic [31:0]      cp0_wdata,
    input  logic [4:0]       cp0_raddr,
    output logic [31:0]      cp0_rdata,
    input  logic [31:0]      pc_x,
    input  logic             intr_ok,
    input  logic             eret,
    output logic             intr_take,
    output logic [31:0]      intr_vector,
    output logic [31:0]      epc,
    output logic             in_handler
);

    cp0_state_t r_state;
    cp0_state_t w_state_nxt;

    logic [31:0]      r_count;
    logic [31:0]      r_compare;
    logic [31:0]      r_epc;
    logic             r_ie;
    logic [5:0]       r_im;       // Status[15:10]
    logic [5:0]       r_ip;       // Cause[15:10], bit 5 = timer
    logic             r_tmr_hit;  // registered Count==Compare
    logic [N_EXT-1:0] w_ext_rise;

    logic w_wr_count, w_wr_compare, w_wr_status, w_wr_cause, w_wr_epc;
    logic w_pending, w_take, w_in_handler;

    irq_sync_edge #(
        .WIDTH (N_EXT),
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (irq_ext),
        .o_rise  (w_ext_rise)
    );

    assign w_wr_count   = cp0_we && (cp0_waddr == CP0_COUNT);
    assign w_wr_compare = cp0_we && (cp0_waddr == CP0_COMPARE);
    assign w_wr_status  = cp0_we && (cp0_waddr == CP0_STATUS);
    assign w_wr_cause   = cp0_we && (cp0_waddr == CP0_CAUSE);
    assign w_wr_epc     = cp0_we && (cp0_waddr == CP0_EPC);

    // Uses the registered IE, so a same-cycle Status write cannot affect the take.
    assign w_pending = r_ie && (|(r_ip & r_im));

    always_comb begin
        w_state_nxt  = r_state;
        w_take       = 1'b0;
        w_in_handler = 1'b0;
        case (r_state)
            RUN: begin
                if (w_pending && intr_ok) begin
                    w_take      = 1'b1;
                    w_state_nxt = HANDLER;
                end
            end
            HANDLER: begin
                w_in_handler = 1'b1;
                if (eret) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= RUN;
            r_count   <= '0;
            r_compare <= '0;
            r_epc     <= '0;
            r_ie      <= 1'b0;
            r_im      <= '0;
            r_ip      <= '0;
            r_tmr_hit <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            r_count <= w_wr_count ? cp0_wdata : r_count + 32'd1;

            if (w_wr_compare) begin
                r_compare <= cp0_wdata;
            end

            // A Compare write suppresses both a pending and a coincident match.
            r_tmr_hit <= (r_count == r_compare) && (r_compare != '0) && !w_wr_compare;
            r_ip[TMR_BIT-IM_LO] <= w_wr_compare ? 1'b0 : (r_ip[TMR_BIT-IM_LO] | r_tmr_hit);

            // Software ack writes the ext IP bits; a new edge always wins.
            r_ip[N_EXT-1:0] <= (w_wr_cause ? cp0_wdata[IM_LO+N_EXT-1:IM_LO] : r_ip[N_EXT-1:0])
                               | w_ext_rise;

            if (w_wr_status) begin
                r_im <= cp0_wdata[IM_HI:IM_LO];
                r_ie <= cp0_wdata[IE_BIT];
            end
            if (w_take) begin
                r_ie <= 1'b0;
            end

            if (w_take) begin
                r_epc <= pc_x;
            end else if (w_wr_epc) begin
                r_epc <= cp0_wdata;
            end
        end
    end

    always_comb begin
        cp0_rdata = '0;
        case (cp0_raddr)
            CP0_COUNT:   cp0_rdata = r_count;
            CP0_COMPARE: cp0_rdata = r_compare;
            CP0_STATUS:  cp0_rdata = {16'b0, r_im, 9'b0, r_ie};
            CP0_CAUSE:   cp0_rdata = {16'b0, r_ip, 10'b0};
            CP0_EPC:     cp0_rdata = r_epc;
            default:     cp0_rdata = '0;
        endcase
    end

    assign intr_take   = w_take;
    assign intr_vector = ISR_VECTOR;
    assign epc         = r_epc;
    assign in_handler  = w_in_handler;

endmodule

// File: tb/tb_cp0_intr_ctrl.sv
// Purpose: self-checking bench for cp0_intr_ctrl with a take scoreboard.
// Latency: expected take cycles are queued at stimulus time.
// Backpressure: n/a.
module tb_cp0_intr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  irq_ext;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic [31:0] pc_x;
    logic        intr_ok;
    logic        eret;
    logic        intr_take;
    logic [31:0] intr_vector;
    logic [31:0] epc;
    logic        in_handler;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    cp0_intr_ctrl #(
        .ISR_VECTOR  (32'h0000_0000),
        .N_EXT       (5),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_ext     (irq_ext),
        .cp0_we      (cp0_we),
        .cp0_waddr   (cp0_waddr),
        .cp0_wdata   (cp0_wdata),
        .cp0_raddr   (cp0_raddr),
        .cp0_rdata   (cp0_rdata),
        .pc_x        (pc_x),
        .intr_ok     (intr_ok),
        .eret        (eret),
        .intr_take   (intr_take),
        .intr_vector (intr_vector),
        .epc         (epc),
        .in_handler  (in_handler)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        cp0_we    = 1'b1;
        cp0_waddr = addr;
        cp0_wdata = data;
        tick();
        cp0_we    = 1'b0;
    endtask

    task automatic rd(input logic [4:0] addr, input logic [31:0] exp, input string tag);
        cp0_raddr = addr;
        #1;
        chk(tag, cp0_rdata, exp);
        tick();
    endtask

    task automatic expect_take(input int at_cyc, input logic [31:0] pc);
        exp_t e;
        e.cyc = at_cyc;
        e.pc  = pc;
        sb_q.push_back(e);
    endtask

    // Every take must match a queued entry in cycle; EPC and residency follow.
    initial begin : take_monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (intr_take === 1'b1) begin
                chk("take_expected", {31'b0, sb_q.size() != 0}, 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("take_cycle", cyc, e.cyc);
                    chk("take_vector", intr_vector, 32'h0000_0000);
                    @(posedge clk);
                    #1;
                    chk("take_epc", epc, e.pc);
                    chk("take_in_handler", {31'b0, in_handler}, 32'd1);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin : stim
        int t;
        rst = 1'b0; irq_ext = '0; cp0_we = 1'b0; cp0_waddr = '0; cp0_wdata = '0;
        cp0_raddr = '0; pc_x = '0; intr_ok = 1'b0; eret = 1'b0;

        // Reset and read-back
        repeat (2) tick();
        chk("rst_take", {31'b0, intr_take}, 32'd0);
        chk("rst_in_handler", {31'b0, in_handler}, 32'd0);
        rd(5'd9,  32'd0, "rst_count");
        rd(5'd11, 32'd0, "rst_compare");
        rd(5'd12, 32'd0, "rst_status");
        rd(5'd13, 32'd0, "rst_cause");
        rd(5'd14, 32'd0, "rst_epc");
        rst = 1'b1;
        rd(5'd9, 32'd0, "count_start");
        rd(5'd9, 32'd1, "count_inc");

        // External take on line 0
        wr(5'd12, 32'h0000_0401);
        irq_ext[0] = 1'b1; intr_ok = 1'b1; pc_x = 32'h40;
        expect_take(cyc + 4, 32'h40);
        repeat (4) tick();
        rd(5'd13, 32'h0000_0400, "ext_cause");
        intr_ok = 1'b0;
        rd(5'd12, 32'h0000_0400, "ext_status_ie0");
        rd(5'd14, 32'h40, "ext_epc");

        // Edge during handler latches but does not take; ack; eret
        irq_ext[1] = 1'b1;
        repeat (5) tick();
        rd(5'd13, 32'h0000_0C00, "hdl_cause");
        chk("hdl_in_handler", {31'b0, in_handler}, 32'd1);
        wr(5'd13, 32'd0);
        rd(5'd13, 32'd0, "hdl_ack");
        eret = 1'b1; tick(); eret = 1'b0;
        chk("eret_run", {31'b0, in_handler}, 32'd0);

        // Masked by IM, then held off by intr_ok, then taken
        wr(5'd12, 32'h0000_0001);
        irq_ext[2] = 1'b1; intr_ok = 1'b1;
        repeat (6) tick();
        rd(5'd13, 32'h0000_1000, "masked_cause");
        intr_ok = 1'b0;
        wr(5'd12, 32'h0000_1001);
        repeat (3) tick();
        pc_x = 32'h80; intr_ok = 1'b1;
        expect_take(cyc, 32'h80);
        tick();
        intr_ok = 1'b0;
        rd(5'd12, 32'h0000_1000, "held_status");
        eret = 1'b1; tick(); eret = 1'b0;

        // Cause clear removes the pending source
        wr(5'd12, 32'h0000_1001);
        wr(5'd13, 32'd0);
        intr_ok = 1'b1;
        repeat (5) tick();
        intr_ok = 1'b0;
        rd(5'd13, 32'd0, "clr_cause");

        // Timer: Compare=0x20, Count loaded to 0x10
        wr(5'd12, 32'h0000_8001);
        wr(5'd11, 32'h20);
        wr(5'd9,  32'h10);
        t = cyc;
        intr_ok = 1'b1; pc_x = 32'h100;
        expect_take(t + 18, 32'h100);
        repeat (17) tick();
        rd(5'd13, 32'd0, "tmr_not_yet");
        rd(5'd13, 32'h0000_8000, "tmr_ip15");
        intr_ok = 1'b0;
        wr(5'd11, 32'h20);
        rd(5'd13, 32'd0, "tmr_cmp_clear");
        eret = 1'b1; tick(); eret = 1'b0;

        // Compare=0 never fires, even through the wrap
        wr(5'd11, 32'd0);
        wr(5'd12, 32'h0000_8001);
        wr(5'd9,  32'hFFFF_FFF0);
        intr_ok = 1'b1;
        repeat (20) tick();
        intr_ok = 1'b0;
        rd(5'd9,  32'h4, "count_wrap");
        rd(5'd13, 32'd0, "cmp0_no_ip");

        // Cause clear coincident with a new edge on the same bit
        wr(5'd12, 32'h0000_0800);
        irq_ext[1] = 1'b0;
        repeat (4) tick();
        irq_ext[1] = 1'b1;
        repeat (3) tick();
        wr(5'd13, 32'd0);
        rd(5'd13, 32'h0000_0800, "set_wins");

        // Status write with IE=1 in the take cycle leaves IE=0
        pc_x = 32'h200; intr_ok = 1'b1;
        wr(5'd12, 32'h0000_0801);
        expect_take(cyc, 32'h200);
        wr(5'd12, 32'h0000_0801);
        intr_ok = 1'b0;
        rd(5'd12, 32'h0000_0800, "take_ie_forced0");

        // Same-cycle read/write returns old value
        cp0_we = 1'b1; cp0_waddr = 5'd14; cp0_wdata = 32'h55; cp0_raddr = 5'd14;
        #1;
        chk("rw_old_epc", cp0_rdata, 32'h200);
        tick();
        cp0_we = 1'b0;
        rd(5'd14, 32'h55, "epc_written");
        eret = 1'b1; tick(); eret = 1'b0;

        // EPC write coincident with take: take wins
        wr(5'd12, 32'h0000_0801);
        pc_x = 32'h300; intr_ok = 1'b1;
        expect_take(cyc, 32'h300);
        cp0_we = 1'b1; cp0_waddr = 5'd14; cp0_wdata = 32'hDEAD;
        tick();
        cp0_we = 1'b0; intr_ok = 1'b0;
        rd(5'd14, 32'h300, "epc_take_wins");

        // Reset mid-handler
        rst = 1'b0; tick(); rst = 1'b1;
        chk("rst_hdl_in_handler", {31'b0, in_handler}, 32'd0);
        rd(5'd13, 32'd0, "rst_hdl_cause");
        rd(5'd12, 32'd0, "rst_hdl_status");
        rd(5'd14, 32'd0, "rst_hdl_epc");
        rd(5'd3,  32'd0, "unimpl_reg");

        repeat (2) tick();
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cp0_intr_ctrl.md
Name: cp0_intr_ctrl

Overview:
- Coprocessor-0 interrupt controller for the 5-stage MIPS core.
- Holds Status(12), Cause(13), EPC(14), Count(9) and Compare(11), and latches five external interrupt lines plus an internal timer.
- When an enabled, unmasked interrupt is pending at an interruptible point, it redirects fetch to the ISR ROM vector, captures EPC and tracks handler residency until eret.
- Serves mfc0/mtc0 from the X stage.

Parameters:
- ISR_VECTOR, 32'h0000_0000, fetch address driven on take (word 0 of ISR ROM).
- N_EXT, 5, external interrupt lines; mapped to Cause/Status bits 14:10.
- SYNC_STAGES, 2, synchronizer depth for external lines.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-low reset (rst==0 resets on clk rising edge)
- irq_ext  in  N_EXT  asynchronous level interrupt sources
- cp0_we  in  1  mtc0 write strobe (X stage)
- cp0_waddr  in  5  mtc0 destination register number
- cp0_wdata  in  32  mtc0 data
- cp0_raddr  in  5  mfc0 source register number
- cp0_rdata  out  32  mfc0 data, combinational from raddr
- pc_x  in  32  PC of instruction in X stage
- intr_ok  in  1  X-stage instruction is interruptible (valid, not delay slot, no stall)
- eret  in  1  handler-return pulse from decoder (jr $k0 marked as return)
- intr_take  out  1  one-cycle redirect/flush pulse
- intr_vector  out  32  constant ISR_VECTOR
- epc  out  32  EPC register, for jr $k0 path
- in_handler  out  1  high from take until eret

Behaviour:
- Reset: Status, Cause, EPC, Count and Compare are 0; state RUN; synchronizers and edge history are 0; intr_take=0; in_handler=0.
- Status: bit0 IE, bits 15:10 IM; all other bits read 0 and ignore writes.
- Cause: bits 15:10 IP (bit15 = timer, 14:10 = ext); all other bits 0.
- External lines: SYNC_STAGES flop synchronizer, then rising-edge detect.
  - An edge sets the sticky IP bit the cycle after detection.
  - A Cause mtc0 writes IP[14:10] (software ack by writing 0).
  - Set and clear of the same bit in the same cycle: set wins.
- Timer:
  - Count increments by 1 every cycle and wraps 0xFFFF_FFFF to 0.
  - An mtc0 to Count loads wdata instead of incrementing.
  - When Count==Compare and Compare!=0, IP[15] is set (sticky).
  - An mtc0 to Compare clears IP[15]; a coincident match the same cycle does not set it.
- pending = |(IP & IM) & IE.
- FSM:
  - RUN: if pending && intr_ok, assert intr_take for exactly one cycle; EPC<=pc_x; IE<=0; go to HANDLER.
  - HANDLER: in_handler=1; no take. On eret go to RUN. IE is not auto-restored; software restores it.
  - eret in RUN is ignored.
- Simultaneous mtc0 to Status and take: written IM bits apply, IE forced 0, and the take decision uses the pre-write IE.
- An mtc0 to EPC is accepted in any state; a take in the same cycle wins.
- cp0_rdata returns 0 for unimplemented register numbers. Read and write of the same register in the same cycle returns the old value.
- Latency:
  - irq pin edge to intr_take: at best SYNC_STAGES+2 cycles.
  - Count match to intr_take: 2 cycles.
- Reset mid-handler returns to RUN with all registers cleared.

Decomposition:
- Package cp0_pkg holds:
  - Register numbers: CP0_COUNT=9, CP0_COMPARE=11, CP0_STATUS=12, CP0_CAUSE=13, CP0_EPC=14.
  - Bit positions: IE=0, IM/IP low=10, high=15, timer bit 15.
  - FSM state enum: RUN, HANDLER.
- Sub-module irq_sync_edge (param width, depth): synchronizer plus registered rising-edge pulse, one instance for irq_ext.

Test Plan:
- Reset then read: rst=0 for 2 cycles -> mfc0 of regs 9/11/12/13/14 returns 0 except Count, which counts from 0 after release; intr_take=0.
- External take: Status=0x0000_0401, raise irq_ext[0] with intr_ok=1 and pc_x=0x40 -> Cause reads 0x0000_0400, intr_take pulses once at SYNC_STAGES+2, EPC=0x40, Status reads 0x0000_0400, in_handler=1.
- Masked/held off: IM=0 or intr_ok=0 -> no take while IP is set. Raising intr_ok then takes next cycle. Writing Cause=0 clears IP and no take follows.
- Timer:
  - Compare=0x20 with Count reset to 0x10 and Status=0x8001 -> IP[15] set at Count=0x20, take 2 cycles after match.
  - Writing Compare clears IP[15].
  - Compare=0 never fires through wrap.
- Handler/eret: during HANDLER a new edge on irq_ext[1] latches IP but causes no take. eret returns to RUN. Software writes IE=1 and the take fires next eligible cycle.
- Collisions:
  - mtc0 Cause clear coincident with a new edge on the same bit -> bit remains 1.
  - mtc0 Status IE=1 in the take cycle -> IE reads 0 after.
